// File: rtl/data_sram_resp_pkg.sv
// Shared bus widths, FSM encodings and address helper for the data SRAM responder.
package data_sram_resp_pkg;

  localparam int unsigned DataSramAddrBus = 32;
  localparam int unsigned DataSramWenBus  = 4;

  localparam logic [1:0] DS_IDLE = 2'd0;
  localparam logic [1:0] DS_WAIT = 2'd1;
  localparam logic [1:0] DS_RESP = 2'd2;

  // Word index relative to the array base; wraps modulo 2^32 so addresses below
  // the base land far out of range.
  function automatic logic [31:0] word_index(input logic [31:0] addr,
                                             input logic [31:0] base);
    logic [31:0] off;
    off = addr - base;
    return off >> 2;
  endfunction

endpackage

// File: rtl/data_sram_resp_if.sv
// Data SRAM bus between EX/MEM (master) and the SRAM responder (slave).
interface data_sram_resp_if;
  import data_sram_resp_pkg::*;

  logic                        data_sram_en;
  logic [DataSramWenBus-1:0]   data_sram_wen;
  logic [DataSramAddrBus-1:0]  data_sram_addr;
  logic [31:0]                 data_sram_wdata;
  logic [31:0]                 data_sram_rdata;
  logic                        resp_valid;
  logic                        stallreq_mem;
  logic                        addr_err;
  logic                        proto_err;

  modport master (
    output data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata,
    input  data_sram_rdata, resp_valid, stallreq_mem, addr_err, proto_err
  );

  modport slave (
    input  data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata,
    output data_sram_rdata, resp_valid, stallreq_mem, addr_err, proto_err
  );

endinterface

// File: rtl/data_sram_resp_dsram_bank.sv
// Single-port byte-enabled word array with a registered read port.
module dsram_bank #(
  parameter int unsigned DEPTH_WORDS = 1024,
  localparam int unsigned AW = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          re,
  input  logic [3:0]    we,
  input  logic          clr,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   din,
  output logic [31:0]   dout
);

  logic [31:0] mem [DEPTH_WORDS];
  logic [31:0] merged;

  // Word as it will read after this cycle's write, giving new-data read-during-write.
  always_comb begin
    merged = mem[addr];
    for (int i = 0; i < 4; i++) begin
      if (we[i]) merged[8*i +: 8] = din[8*i +: 8];
    end
  end

  // Lane-masked write; contents are never cleared.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (we[i]) mem[addr][8*i +: 8] <= din[8*i +: 8];
    end
  end

  // Output register only moves on a read or an explicit clear, so it holds otherwise.
  always_ff @(posedge clk) begin
    if (rst)      dout <= 32'h0;
    else if (clr) dout <= 32'h0;
    else if (re)  dout <= merged;
  end

endmodule

// File: rtl/data_sram_resp.sv
// Data SRAM responder: request FSM with configurable wait latency, range check,
// protocol-error flag and a byte-writable backing array.
module data_sram_resp
  import data_sram_resp_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned WAIT_CYCLES = 0
) (
  input logic                 clk,
  input logic                 rst,
  data_sram_resp_if.slave     bus
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);
  localparam logic [3:0] CntLoad = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

  logic [1:0]  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, wdata_q;
  logic [3:0]  wen_q;
  logic        addr_err_q, proto_err_q;

  logic        capture, commit, acc_ok, in_range;
  logic [31:0] c_addr, c_wdata, idx;
  logic [3:0]  c_wen;
  logic        bank_re, bank_clr;
  logic [3:0]  bank_we;

  // Next state; commit marks the edge that enters RESP and selects its operands.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    capture = 1'b0;
    commit  = 1'b0;
    c_addr  = bus.data_sram_addr;
    c_wen   = bus.data_sram_wen;
    c_wdata = bus.data_sram_wdata;
    case (state_q)
      DS_IDLE, DS_RESP: begin
        if (bus.data_sram_en) begin
          capture = 1'b1;
          if (WAIT_CYCLES == 0) begin
            state_d = DS_RESP;
            commit  = 1'b1;
          end else begin
            state_d = DS_WAIT;
            cnt_d   = CntLoad;
          end
        end else begin
          state_d = DS_IDLE;
        end
      end
      DS_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = DS_RESP;
          commit  = 1'b1;
          c_addr  = addr_q;
          c_wen   = wen_q;
          c_wdata = wdata_q;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = DS_IDLE;
    endcase
  end

  // Range check and bank controls; reset on the commit edge drops the access.
  always_comb begin
    idx      = word_index(c_addr, BASE_ADDR);
    in_range = (idx < DEPTH_WORDS);
    acc_ok   = commit & ~rst;
    bank_re  = acc_ok & in_range & (c_wen == 4'h0);
    bank_we  = (acc_ok & in_range) ? c_wen : 4'h0;
    bank_clr = acc_ok & ~in_range & (c_wen == 4'h0);
  end

  // FSM, counter, captured request and error flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= DS_IDLE;
      cnt_q       <= 4'd0;
      addr_q      <= 32'h0;
      wen_q       <= 4'h0;
      wdata_q     <= 32'h0;
      addr_err_q  <= 1'b0;
      proto_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_err_q <= acc_ok & ~in_range;
      if (capture) begin
        addr_q  <= bus.data_sram_addr;
        wen_q   <= bus.data_sram_wen;
        wdata_q <= bus.data_sram_wdata;
      end
      if (state_q == DS_WAIT && bus.data_sram_en) proto_err_q <= 1'b1;
    end
  end

  dsram_bank #(
    .DEPTH_WORDS (DEPTH_WORDS)
  ) u_bank (
    .clk  (clk),
    .rst  (rst),
    .re   (bank_re),
    .we   (bank_we),
    .clr  (bank_clr),
    .addr (idx[AW-1:0]),
    .din  (c_wdata),
    .dout (bus.data_sram_rdata)
  );

  assign bus.resp_valid   = (state_q == DS_RESP);
  assign bus.stallreq_mem = (state_q == DS_WAIT);
  assign bus.addr_err     = addr_err_q;
  assign bus.proto_err    = proto_err_q;

endmodule

// File: tb/tb_data_sram_resp.sv
// Scoreboard bench: two responders (0 and 3 wait cycles) driven with directed vectors.
module tb_data_sram_resp;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst0, rst3;
  data_sram_resp_if bus0 ();
  data_sram_resp_if bus3 ();

  data_sram_resp #(
    .DEPTH_WORDS (1024),
    .BASE_ADDR   (32'h0),
    .WAIT_CYCLES (0)
  ) u_dut0 (
    .clk (clk),
    .rst (rst0),
    .bus (bus0.slave)
  );

  data_sram_resp #(
    .DEPTH_WORDS (1024),
    .BASE_ADDR   (32'h0),
    .WAIT_CYCLES (3)
  ) u_dut3 (
    .clk (clk),
    .rst (rst3),
    .bus (bus3.slave)
  );

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t        q0[$];
  exp_t        q3[$];
  exp_t        e0, e3;
  int          total = 0;
  int          bad = 0;
  int          stall_seen0 = 0;
  logic [31:0] last0 = 32'h0;
  logic [31:0] last3 = 32'h0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Monitor: every response pops one expectation.
  always @(negedge clk) begin
    if (bus0.stallreq_mem) stall_seen0++;
    if (bus0.resp_valid) begin
      if (q0.size() == 0) begin
        total++;
        bad++;
        $display("FAIL u0 unexpected response: got rdata %h want none", bus0.data_sram_rdata);
      end else begin
        e0 = q0.pop_front();
        chk("u0 rdata", bus0.data_sram_rdata, e0.rdata);
        chk("u0 addr_err", {31'b0, bus0.addr_err}, {31'b0, e0.err});
      end
    end
    if (bus3.resp_valid) begin
      if (q3.size() == 0) begin
        total++;
        bad++;
        $display("FAIL u3 unexpected response: got rdata %h want none", bus3.data_sram_rdata);
      end else begin
        e3 = q3.pop_front();
        chk("u3 rdata", bus3.data_sram_rdata, e3.rdata);
        chk("u3 addr_err", {31'b0, bus3.addr_err}, {31'b0, e3.err});
      end
    end
  end

  // Drive one request for a cycle; called just after a posedge.
  task automatic issue(input int sel, input logic [3:0] wen, input logic [31:0] addr,
                       input logic [31:0] wdata, input bit push,
                       input logic [31:0] erd, input logic eerr);
    if (sel == 0) begin
      bus0.data_sram_en = 1'b1; bus0.data_sram_wen = wen;
      bus0.data_sram_addr = addr; bus0.data_sram_wdata = wdata;
      if (push) q0.push_back({erd, eerr});
    end else begin
      bus3.data_sram_en = 1'b1; bus3.data_sram_wen = wen;
      bus3.data_sram_addr = addr; bus3.data_sram_wdata = wdata;
      if (push) q3.push_back({erd, eerr});
    end
    @(posedge clk);
    #1;
    bus0.data_sram_en = 1'b0;
    bus3.data_sram_en = 1'b0;
  endtask

  task automatic wr(input int sel, input logic [3:0] wen, input logic [31:0] addr,
                    input logic [31:0] wdata, input logic eerr);
    issue(sel, wen, addr, wdata, 1'b1, (sel == 0) ? last0 : last3, eerr);
  endtask

  task automatic rd(input int sel, input logic [31:0] addr, input logic [31:0] erd,
                    input logic eerr);
    if (sel == 0) last0 = erd;
    else last3 = erd;
    issue(sel, 4'h0, addr, 32'h0, 1'b1, erd, eerr);
  endtask

  // Count negedges (with stall) until the u3 response; bounded.
  task automatic wait_resp3(input string name, input int lat, input int stalls);
    int  n = 0;
    int  s = 0;
    bit  got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      n++;
      if (bus3.stallreq_mem) s++;
      if (bus3.resp_valid) got = 1;
    end
    chk({name, " resp seen"}, {31'b0, got}, 32'd1);
    chk({name, " latency"}, n, lat);
    chk({name, " stall cycles"}, s, stalls);
    @(posedge clk);
    #1;
  endtask

  initial begin
    bus0.data_sram_en = 1'b0; bus0.data_sram_wen = 4'h0;
    bus0.data_sram_addr = 32'h0; bus0.data_sram_wdata = 32'h0;
    bus3.data_sram_en = 1'b0; bus3.data_sram_wen = 4'h0;
    bus3.data_sram_addr = 32'h0; bus3.data_sram_wdata = 32'h0;
    rst0 = 1'b1;
    rst3 = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset rdata", bus0.data_sram_rdata | bus3.data_sram_rdata, 32'h0);
    chk("reset resp_valid", {31'b0, bus0.resp_valid | bus3.resp_valid}, 32'd0);
    chk("reset stall", {31'b0, bus0.stallreq_mem | bus3.stallreq_mem}, 32'd0);
    chk("reset errs", {30'b0, bus0.addr_err | bus3.addr_err, bus0.proto_err | bus3.proto_err},
        32'd0);
    rst0 = 1'b0;
    rst3 = 1'b0;
    @(posedge clk);
    #1;

    // Zero-wait: back-to-back write then read, byte lanes, range checks.
    wr(0, 4'hF, 32'h10, 32'hDEADBEEF, 1'b0);
    rd(0, 32'h10, 32'hDEADBEEF, 1'b0);
    wr(0, 4'hF, 32'h20, 32'h11223344, 1'b0);
    wr(0, 4'b0101, 32'h20, 32'hAABBCCDD, 1'b0);
    rd(0, 32'h20, 32'h11BB33DD, 1'b0);
    rd(0, 32'h13, 32'hDEADBEEF, 1'b0);
    wr(0, 4'hF, 32'h0, 32'hCAFEF00D, 1'b0);
    wr(0, 4'hF, 32'hFFC, 32'h12345678, 1'b0);
    rd(0, 32'hFFC, 32'h12345678, 1'b0);
    rd(0, 32'h1000, 32'h0, 1'b1);
    wr(0, 4'hF, 32'h1000, 32'h55555555, 1'b1);
    rd(0, 32'h0, 32'hCAFEF00D, 1'b0);
    @(posedge clk);
    #1;
    chk("u0 idle resp_valid", {31'b0, bus0.resp_valid}, 32'd0);
    chk("u0 idle rdata hold", bus0.data_sram_rdata, 32'hCAFEF00D);

    // Three-wait: latency and stall window.
    wr(3, 4'hF, 32'h10, 32'hDEADBEEF, 1'b0);
    wait_resp3("u3 write", 4, 3);
    rd(3, 32'h10, 32'hDEADBEEF, 1'b0);
    wait_resp3("u3 read", 4, 3);
    wr(3, 4'hF, 32'h30, 32'h0BADC0DE, 1'b0);
    wait_resp3("u3 write30", 4, 3);
    chk("u3 proto_err before", {31'b0, bus3.proto_err}, 32'd0);

    // Request during WAIT is ignored and flags proto_err.
    rd(3, 32'h10, 32'hDEADBEEF, 1'b0);
    issue(3, 4'hF, 32'h30, 32'hFFFFFFFF, 1'b0, 32'h0, 1'b0);
    wait_resp3("u3 violated read", 3, 2);
    chk("u3 proto_err set", {31'b0, bus3.proto_err}, 32'd1);
    rd(3, 32'h30, 32'h0BADC0DE, 1'b0);
    wait_resp3("u3 read30", 4, 3);
    chk("u3 proto_err sticky", {31'b0, bus3.proto_err}, 32'd1);

    // Reset in the second WAIT cycle drops the pending write.
    wr(3, 4'hF, 32'h40, 32'h40404040, 1'b0);
    wait_resp3("u3 write40", 4, 3);
    issue(3, 4'hF, 32'h40, 32'h99999999, 1'b0, 32'h0, 1'b0);
    @(posedge clk);
    #1;
    rst3 = 1'b1;
    @(posedge clk);
    #1;
    rst3 = 1'b0;
    last3 = 32'h0;
    chk("u3 post-reset rdata", bus3.data_sram_rdata, 32'h0);
    chk("u3 post-reset flags",
        {28'b0, bus3.resp_valid, bus3.stallreq_mem, bus3.addr_err, bus3.proto_err}, 32'd0);
    repeat (5) @(posedge clk);
    #1;
    rd(3, 32'h40, 32'h40404040, 1'b0);
    wait_resp3("u3 read40", 4, 3);

    repeat (2) @(posedge clk);
    #1;
    chk("u0 queue drained", q0.size(), 32'd0);
    chk("u3 queue drained", q3.size(), 32'd0);
    chk("u0 never stalled", stall_seen0, 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
